// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: controller states,
// round count, round constants and the S-box.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  localparam int NR = 10;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Inverse as a^254 (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv
      ^ {inv[6:0], inv[7]}
      ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]}
      ^ {inv[3:0], inv[7:4]}
      ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: next round key
// from the current key and the round constant.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [7:0]   rc,
  output logic [127:0] key_out
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_t;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign w_w0 = key_in[127:96];
  assign w_w1 = key_in[95:64];
  assign w_w2 = key_in[63:32];
  assign w_w3 = key_in[31:0];

  // SubWord(RotWord(w3)) with rcon in the top byte
  assign w_t = {
    sbox(w_w3[23:16]),
    sbox(w_w3[15:8]),
    sbox(w_w3[7:0]),
    sbox(w_w3[31:24])
  } ^ {rc, 24'h0};

  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign key_out = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption controller: holds
// state and round key, sequences an external round.
module aes_round_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic [127:0] dp_block,
  output logic [127:0] dp_round_key,
  output logic         dp_last,
  input  logic [127:0] dp_result,
  output logic [3:0]   round,
  output logic         busy
);

  localparam logic [3:0] NR_L = 4'(NR);

  state_t       r_state;
  state_t       w_next;
  logic [127:0] r_blk;
  logic [127:0] r_key;
  logic [3:0]   r_round;

  logic         w_idle;
  logic         w_fin;
  logic [127:0] w_key_src;
  logic [127:0] w_key_nxt;
  logic [7:0]   w_rc;

  assign w_idle = (r_state == IDLE);
  assign w_fin  = (r_state == ROUND)
               && (r_round == NR_L);

  // One key-step unit serves both accept and rounds
  assign w_key_src = w_idle ? in_key : r_key;
  assign w_rc      = rcon(w_idle ? 4'd1
                                 : r_round + 4'd1);

  aes_key_step u_key_step (
    .key_in  (w_key_src),
    .rc      (w_rc),
    .key_out (w_key_nxt)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = ROUND;
      ROUND:   if (w_fin)     w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk   <= '0;
      r_key   <= '0;
      r_round <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_blk   <= in_block ^ in_key;
            r_key   <= w_key_nxt;
            r_round <= 4'd1;
          end
        end
        ROUND: begin
          r_blk <= dp_result;
          if (!w_fin) begin
            r_key   <= w_key_nxt;
            r_round <= r_round + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) r_round <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = w_idle;
  assign out_valid    = (r_state == DONE);
  assign busy         = !w_idle;
  assign out_block    = r_blk;
  assign dp_block     = r_blk;
  assign dp_round_key = r_key;
  assign dp_last      = w_fin;
  assign round        = r_round;

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES-128 encryption controller. It accepts a plaintext/key pair over a valid/ready handshake and holds the cipher state and current round key. It sequences a single-round combinational datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey) through rounds 1..10 and generates each round key on the fly. It then presents the ciphertext over a second valid/ready handshake and sits between the bus-side wrapper and the round datapath.

## Interface
- NR, 10, number of rounds (AES-128 only; other values unsupported)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  plaintext/key pair offered
- in_ready  out  1  controller can accept a pair
- in_block  in  128  plaintext; [127:120] = FIPS byte 0, column-major
- in_key  in  128  cipher key, same byte order
- out_valid  out  1  ciphertext available
- out_ready  in  1  downstream accepts ciphertext
- out_block  out  128  ciphertext (= state register)
- dp_block  out  128  current state to round datapath
- dp_round_key  out  128  key for the round being computed
- dp_last  out  1  final round: datapath bypasses MixColumns
- dp_result  in  128  combinational round result from datapath
- round  out  4  current round index, 0 when idle
- busy  out  1  high in ROUND and DONE

## Operation
- FSM states: IDLE, ROUND, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready: state_reg ← in_block ^ in_key (round-0 AddRoundKey); key_reg ← key_step(in_key, rcon[1]); round ← 1; → ROUND.
- ROUND: dp_block=state_reg, dp_round_key=key_reg, dp_last=(round==NR). Each cycle state_reg ← dp_result. If round<NR: key_reg ← key_step(key_reg, rcon[round+1]), round ← round+1. If round==NR: → DONE; key_reg and round hold.
- DONE: out_valid=1, out_block=state_reg held stable. On out_valid&&out_ready: round ← 0 → IDLE.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 (placed in byte [127:120] position of word w0).
- key_step(w0..w3, rc): t = SubWord(RotWord(w3)) ^ {rc,24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'. Words are 32-bit; w0 = key[127:96].
- in_ready=1 only in IDLE; in_valid while busy is ignored, and upstream holds its data.
- No input/output overlap: a new pair is accepted no earlier than the cycle after the output handshake.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, round=0, dp_last=0, state_reg=0 (so out_block=dp_block=0), key_reg=0 (dp_round_key=0).
- Accept at edge E: round=1 from E. Round r result captured at edge E+r. out_valid rises after E+10, giving 10 cycles from accept to first out_valid cycle.
- Minimum period per block: 12 cycles (accept, 10 rounds, handshake in DONE, 1 cycle IDLE).
- out_ready low: DONE held indefinitely, out_block unchanged.
- out_ready high on the first DONE cycle: handshake completes that cycle; IDLE next.
- Reset asserted mid-operation: immediate return to IDLE with reset values; no partial output is ever presented.
- dp_result is sampled only in ROUND and ignored elsewhere.

## Structure
- Package aes_pkg: state enum {IDLE, ROUND, DONE}, NR constant, rcon table, sbox function (shared with the round datapath).
- Sub-module aes_key_step: combinational key_step(key_in, rc) → key_out, 4 S-box lookups. The controller instantiates it once, muxing input between in_key (IDLE) and key_reg (ROUND).
- The round datapath is external; the bench instantiates the team's round datapath and ties dp_* to it.

## Test plan
- FIPS-197 App. B: block 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c → out_block 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after accept. dp_round_key in round 1 = a0fafe1788542cb123a339392a6c7605; in round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with dp_last=1.
- FIPS-197 C.1: block 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → out_block stable, in_ready=0 throughout. Then out_ready=1 → one handshake, in_ready=1 next cycle.
- Busy input: toggle in_valid with different data during ROUND → ignored; result equals the first accepted pair.
- Reset at round 5: assert rst_n=0 → out_valid=0, round=0, in_ready=1 immediately. A fresh App. B run then yields 3925841d… correctly.
- Back-to-back: 208 random pairs with out_ready=1 and in_valid always high → every result matches the reference model, 12-cycle spacing.
